// File: rtl/apa102_read_arbiter.sv
// Round-robin arbiter sharing one pattern-memory read port between up to
// four strip channels, one read in flight, with a response timeout.
//
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   req_request       : per-channel level read request
//   req_address       : packed per-channel addresses, channel i at [i*W +: W]
//   req_data          : shared read data, valid with a done strobe
//   req_done_strobe   : one-hot, one cycle, marks whose data is on req_data
//   mem_address       : memory read address
//   mem_read_strobe   : one-cycle read command
//   mem_read_data     : memory response data
//   mem_read_valid    : one-cycle memory response strobe
//   busy              : high whenever not idle
//   timeout_error     : sticky, set when a read is abandoned
module apa102_read_arbiter #(
  parameter int CHANNELS          = 2,
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int TIMEOUT           = 255
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [CHANNELS-1:0]                   req_request,
  input  logic [CHANNELS*ADDRESS_BUS_WIDTH-1:0] req_address,
  output logic [15:0]                           req_data,
  output logic [CHANNELS-1:0]                   req_done_strobe,
  output logic [ADDRESS_BUS_WIDTH-1:0]          mem_address,
  output logic                                  mem_read_strobe,
  input  logic [15:0]                           mem_read_data,
  input  logic                                  mem_read_valid,
  output logic                                  busy,
  output logic                                  timeout_error
);

  localparam int W = ADDRESS_BUS_WIDTH;
  localparam logic [1:0] LAST_RST = 2'(CHANNELS - 1);
  localparam logic [7:0] TO_VAL   = 8'(TIMEOUT);
  localparam logic [2:0] CH3      = 3'(CHANNELS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e                state_q;
  logic [1:0]            grant_q;
  logic [1:0]            last_grant_q;
  logic [7:0]            cnt_q;
  logic [7:0]            cnt_d;
  logic [15:0]           data_q;
  logic [CHANNELS-1:0]   done_q;
  logic [CHANNELS-1:0]   done_d;
  logic [W-1:0]          addr_q;
  logic                  strobe_q;
  logic                  busy_q;
  logic                  err_q;

  logic [3:0]            req_pad;
  logic [W-1:0]          addr_arr [4];
  logic [2:0]            cand;
  logic                  win_found;
  logic [1:0]            win_idx;

  // Padding to four channels keeps indexing legal for any CHANNELS.
  always_comb begin
    req_pad = 4'(req_request);
    for (int i = 0; i < 4; i++) addr_arr[i] = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      addr_arr[i] = req_address[i*W +: W];
    end
  end

  // Search starts one past the last winner; cand < 2*CHANNELS so a
  // single subtraction performs the wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      cand = {1'b0, last_grant_q} + 3'(k);
      if (cand >= CH3) cand = cand - CH3;
      if (!win_found && req_pad[cand[1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[1:0];
      end
    end
  end

  always_comb begin
    done_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      done_d[i] = (grant_q == 2'(i));
    end
    cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_RST;
      cnt_q        <= '0;
      data_q       <= '0;
      done_q       <= '0;
      addr_q       <= '0;
      strobe_q     <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= '0;
          if (win_found) begin
            grant_q      <= win_idx;
            last_grant_q <= win_idx;
            addr_q       <= addr_arr[win_idx];
            strobe_q     <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          strobe_q <= 1'b0;
          cnt_q    <= '0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_d;
          // A response in the final cycle still wins over the timeout.
          if (mem_read_valid) begin
            data_q  <= mem_read_data;
            done_q  <= done_d;
            state_q <= S_DONE;
          end else if (cnt_d == TO_VAL) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_DONE: begin
          done_q  <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_data        = data_q;
  assign req_done_strobe = done_q;
  assign mem_address     = addr_q;
  assign mem_read_strobe = strobe_q;
  assign busy            = busy_q;
  assign timeout_error   = err_q;

endmodule

// File: tb/tb_apa102_read_arbiter.sv
// Bench for apa102_read_arbiter: CHANNELS=2, TIMEOUT=8, randomized
// memory latency and contents, order predicted from round-robin rules.
module tb_apa102_read_arbiter;

  localparam int CH = 2;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  req_request = '0;
  logic [31:0] req_address = '0;
  logic [15:0] req_data;
  logic [1:0]  req_done_strobe;
  logic [15:0] mem_address;
  logic        mem_read_strobe;
  logic [15:0] mem_read_data = '0;
  logic        mem_read_valid = 1'b0;
  logic        busy;
  logic        timeout_error;

  apa102_read_arbiter #(
    .CHANNELS(CH),
    .ADDRESS_BUS_WIDTH(16),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_request(req_request),
    .req_address(req_address),
    .req_data(req_data),
    .req_done_strobe(req_done_strobe),
    .mem_address(mem_address),
    .mem_read_strobe(mem_read_strobe),
    .mem_read_data(mem_read_data),
    .mem_read_valid(mem_read_valid),
    .busy(busy),
    .timeout_error(timeout_error)
  );

  always #5 clk = ~clk;

  int          nvec = 0;
  int          nerr = 0;
  int          pend = 0;
  logic [15:0] pend_addr = '0;
  bit          rsp_en = 1'b0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  logic [15:0] seed16 = '0;

  function automatic logic [15:0] data_of(input logic [15:0] a);
    if (a == 16'h0010) return 16'hBEEF;
    return 16'(a * 16'h9E37) ^ seed16 ^ 16'h5A5A;
  endfunction

  // One clock; also plays the memory, answering L cycles after a strobe.
  task automatic tick();
    @(posedge clk);
    #1;
    mem_read_valid = 1'b0;
    mem_read_data  = 16'($urandom);
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        mem_read_valid = 1'b1;
        mem_read_data  = data_of(pend_addr);
      end
    end
    if (mem_read_strobe && rsp_en && rst_n) begin
      pend      = int'($urandom_range(lat_hi, lat_lo));
      pend_addr = mem_address;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_request = '0;
    req_address = '0;
    pend = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    nvec++;
    if ({req_data, req_done_strobe, mem_address} !== '0) begin
      nerr++;
      $display("FAIL reset_data: got %h/%b/%h required 0/0/0",
               req_data, req_done_strobe, mem_address);
    end
    nvec++;
    if ({mem_read_strobe, busy, timeout_error} !== 3'b000) begin
      nerr++;
      $display("FAIL reset_ctl: got %b%b%b required 000",
               mem_read_strobe, busy, timeout_error);
    end
    rst_n = 1'b1;
    tick();
    nvec++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL reset_idle_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_single();
    int strobes = 0;
    do_reset();
    rsp_en = 1'b1;
    lat_lo = 2;
    lat_hi = 2;
    req_address[15:0] = 16'h0010;
    req_request = 2'b01;
    for (int c = 1; c <= 7; c++) begin
      tick();
      strobes += int'(mem_read_strobe);
      if (c == 1) begin
        req_request = 2'b00;
        nvec++;
        if (mem_read_strobe !== 1'b1 || mem_address !== 16'h0010) begin
          nerr++;
          $display("FAIL single_strobe: got %b @%h required 1 @0010",
                   mem_read_strobe, mem_address);
        end
      end
      nvec++;
      if (c == 4) begin
        if (req_done_strobe !== 2'b01 || req_data !== 16'hBEEF) begin
          nerr++;
          $display("FAIL single_done: got %b %h required 01 beef",
                   req_done_strobe, req_data);
        end
      end else if (req_done_strobe !== 2'b00) begin
        nerr++;
        $display("FAIL single_nodone c%0d: got %b required 00",
                 c, req_done_strobe);
      end
      if (c == 5) begin
        nvec++;
        if (busy !== 1'b0) begin
          nerr++;
          $display("FAIL single_busy: got %b required 0", busy);
        end
      end
    end
    nvec++;
    if (strobes != 1) begin
      nerr++;
      $display("FAIL single_strobe_count: got %0d required 1", strobes);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] a [2];
    logic [1:0]  exp_oh;
    int          n = 0;
    do_reset();
    rsp_en = 1'b1;
    lat_lo = 1;
    lat_hi = TO;
    a[0] = 16'($urandom);
    a[1] = 16'($urandom);
    req_address = {a[1], a[0]};
    req_request = 2'b11;
    for (int cyc = 0; cyc < 300 && n < 6; cyc++) begin
      tick();
      if (mem_read_strobe) begin
        nvec++;
        if (mem_address !== a[n%2]) begin
          nerr++;
          $display("FAIL rr_addr %0d: got %h required %h",
                   n, mem_address, a[n%2]);
        end
      end
      if (req_done_strobe !== 2'b00) begin
        exp_oh = 2'(1 << (n % 2));
        nvec++;
        if (req_done_strobe !== exp_oh ||
            req_data !== data_of(a[n%2])) begin
          nerr++;
          $display("FAIL rr_done %0d: got %b %h required %b %h", n,
                   req_done_strobe, req_data, exp_oh, data_of(a[n%2]));
        end
        n++;
        if (n == 6) req_request = 2'b00;
      end
    end
    nvec++;
    if (n != 6) begin
      nerr++;
      $display("FAIL rr_count: got %0d reads required 6", n);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      int          rem [2];
      int          r [2];
      logic [15:0] cur [2];
      int          expq [$];
      int          last;
      int          ch;
      bit          found;
      do_reset();
      rsp_en = 1'b1;
      lat_lo = 1;
      lat_hi = TO;
      for (int i = 0; i < 2; i++) begin
        rem[i] = int'($urandom_range(4, 1));
        r[i]   = rem[i];
        cur[i] = 16'($urandom);
      end
      last = CH - 1;
      while (r[0] + r[1] > 0) begin
        found = 1'b0;
        for (int k = 1; k <= CH; k++) begin
          ch = (last + k) % CH;
          if (!found && r[ch] > 0) begin
            found = 1'b1;
            expq.push_back(ch);
            r[ch]--;
            last = ch;
          end
        end
      end
      req_address = {cur[1], cur[0]};
      req_request = 2'b11;
      for (int cyc = 0; cyc < 600 && expq.size() > 0; cyc++) begin
        tick();
        if (mem_read_strobe) begin
          nvec++;
          if (mem_address !== cur[expq[0]]) begin
            nerr++;
            $display("FAIL rand_addr: got %h required %h",
                     mem_address, cur[expq[0]]);
          end
        end
        if (req_done_strobe !== 2'b00) begin
          ch = expq.pop_front();
          nvec++;
          if (req_done_strobe !== 2'(1 << ch) ||
              req_data !== data_of(cur[ch])) begin
            nerr++;
            $display("FAIL rand_done: got %b %h required %b %h",
                     req_done_strobe, req_data, 2'(1 << ch),
                     data_of(cur[ch]));
          end
          rem[ch]--;
          if (rem[ch] == 0) begin
            req_request[ch] = 1'b0;
          end else begin
            cur[ch] = 16'($urandom);
            req_address[ch*16 +: 16] = cur[ch];
          end
        end
      end
      nvec++;
      if (expq.size() != 0) begin
        nerr++;
        $display("FAIL rand_budget: got %0d reads left required 0",
                 expq.size());
      end
    end
  endtask

  task automatic test_timeout();
    bit got = 1'b0;
    do_reset();
    rsp_en = 1'b0;
    req_address[15:0] = 16'h0123;
    req_request = 2'b01;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) req_request = 2'b00;
      nvec++;
      if (req_done_strobe !== 2'b00) begin
        nerr++;
        $display("FAIL to_nodone c%0d: got %b required 00",
                 c, req_done_strobe);
      end
      nvec++;
      if (timeout_error !== (c >= TO + 2)) begin
        nerr++;
        $display("FAIL to_err c%0d: got %b required %b",
                 c, timeout_error, c >= TO + 2);
      end
      if (c == TO + 1 || c == TO + 2) begin
        nvec++;
        if (busy !== (c == TO + 1)) begin
          nerr++;
          $display("FAIL to_busy c%0d: got %b required %b",
                   c, busy, c == TO + 1);
        end
      end
    end
    rsp_en = 1'b1;
    lat_lo = 3;
    lat_hi = 3;
    req_request = 2'b01;
    for (int c = 0; c < 30 && !got; c++) begin
      tick();
      if (mem_read_strobe) req_request = 2'b00;
      if (req_done_strobe !== 2'b00) begin
        got = 1'b1;
        nvec++;
        if (req_done_strobe !== 2'b01 || req_data !== data_of(16'h0123) ||
            timeout_error !== 1'b1) begin
          nerr++;
          $display("FAIL to_recover: got %b %h err%b required 01 %h err1",
                   req_done_strobe, req_data, timeout_error,
                   data_of(16'h0123));
        end
      end
    end
    nvec++;
    if (!got) begin
      nerr++;
      $display("FAIL to_recover_budget: got no done required one");
    end
  endtask

  task automatic test_drop_and_stray();
    logic [15:0] a;
    logic [15:0] keep;
    do_reset();
    rsp_en = 1'b1;
    lat_lo = 4;
    lat_hi = 4;
    a = 16'($urandom);
    req_address[31:16] = a;
    req_request = 2'b10;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) begin
        nvec++;
        if (mem_read_strobe !== 1'b1 || mem_address !== a) begin
          nerr++;
          $display("FAIL drop_strobe: got %b @%h required 1 @%h",
                   mem_read_strobe, mem_address, a);
        end
        req_request = 2'b00;
        req_address = {~a, 16'($urandom)};
      end
      nvec++;
      if (c == 6) begin
        if (req_done_strobe !== 2'b10 || req_data !== data_of(a) ||
            mem_address !== a) begin
          nerr++;
          $display("FAIL drop_done: got %b %h @%h required 10 %h @%h",
                   req_done_strobe, req_data, mem_address, data_of(a), a);
        end
      end else if (req_done_strobe !== 2'b00) begin
        nerr++;
        $display("FAIL drop_nodone c%0d: got %b required 00",
                 c, req_done_strobe);
      end
    end
    keep = data_of(a);
    for (int s = 0; s < 2; s++) begin
      mem_read_valid = 1'b1;
      mem_read_data  = ~keep ^ 16'(s);
      tick();
      nvec++;
      if (req_data !== keep || req_done_strobe !== 2'b00 ||
          busy !== 1'b0 || mem_read_strobe !== 1'b0) begin
        nerr++;
        $display("FAIL stray %0d: got %h %b b%b s%b required %h 00 b0 s0",
                 s, req_data, req_done_strobe, busy, mem_read_strobe, keep);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [15:0] a0;
    bit          got = 1'b0;
    do_reset();
    rsp_en = 1'b1;
    lat_lo = 6;
    lat_hi = 6;
    a0 = 16'($urandom) | 16'h0001;
    req_address = {16'($urandom) | 16'h0001, a0};
    req_request = 2'b11;
    tick();
    tick();
    tick();
    #1;
    rst_n = 1'b0;
    req_request = 2'b00;
    #1;
    nvec++;
    if ({req_data, req_done_strobe, mem_address, mem_read_strobe,
         busy, timeout_error} !== '0) begin
      nerr++;
      $display("FAIL midrst_async: got %h %b %h %b %b %b required zeros",
               req_data, req_done_strobe, mem_address, mem_read_strobe,
               busy, timeout_error);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 5; c <= 9; c++) begin
      tick();
      nvec++;
      if (req_done_strobe !== 2'b00 || req_data !== 16'h0 ||
          busy !== 1'b0) begin
        nerr++;
        $display("FAIL midrst_late c%0d: got %b %h b%b required 00 0 b0",
                 c, req_done_strobe, req_data, busy);
      end
    end
    lat_lo = 2;
    lat_hi = 2;
    req_request = 2'b11;
    for (int c = 0; c < 30 && !got; c++) begin
      tick();
      if (req_done_strobe !== 2'b00) begin
        got = 1'b1;
        req_request = 2'b00;
        nvec++;
        if (req_done_strobe !== 2'b01 || req_data !== data_of(a0)) begin
          nerr++;
          $display("FAIL midrst_restart: got %b %h required 01 %h",
                   req_done_strobe, req_data, data_of(a0));
        end
      end
    end
    nvec++;
    if (!got) begin
      nerr++;
      $display("FAIL midrst_budget: got no done required one");
    end
  endtask

  initial begin
    seed16 = 16'($urandom);
    test_reset();
    test_single();
    test_round_robin();
    test_random();
    test_timeout();
    test_drop_and_stray();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
